// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter: cascaded up/down counter where each digit has its own modulus.
// Loads are clamped per digit, and the terminal step either wraps or saturates.
module bcd_chain_counter #(
    parameter int                  DIGITS = 4,
    parameter logic [4*DIGITS-1:0] MODULI = 16'h6AAA,
    parameter bit                  WRAP   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  up_down,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  carry_out,
    output logic                  overflow,
    output logic                  load_error,
    output logic                  at_max,
    output logic                  at_zero
);
    logic [4*DIGITS-1:0] digits_d, digits_q;
    logic                carry_d, carry_q;
    logic                ovf_d, ovf_q;
    logic                lerr_d, lerr_q;
    logic                ripple, terminal;
    logic [3:0]          fld, lim;

    always_comb begin
        at_max  = 1'b1;
        at_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            at_max  &= digits_q[4*i +: 4] == MODULI[4*i +: 4] - 4'd1;
            at_zero &= digits_q[4*i +: 4] == 4'd0;
        end
    end

    // The ripple enable walks up the chain in one cycle; a digit steps only
    // while every digit below it sits at its rollover value.
    always_comb begin
        digits_d = digits_q;
        carry_d  = 1'b0;
        ovf_d    = ovf_q;
        lerr_d   = 1'b0;
        ripple   = 1'b1;
        fld      = '0;
        lim      = '0;
        terminal = up_down ? at_max : at_zero;
        if (clear) begin
            digits_d = '0;
            ovf_d    = 1'b0;
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                fld = load_value[4*i +: 4];
                lim = MODULI[4*i +: 4] - 4'd1;
                digits_d[4*i +: 4] = fld > lim ? lim : fld;
                lerr_d |= fld > lim;
            end
        end else if (enable) begin
            ovf_d   = ovf_q | terminal;
            carry_d = WRAP && terminal;
            if (WRAP || !terminal) begin
                for (int i = 0; i < DIGITS; i++) begin
                    fld = digits_q[4*i +: 4];
                    lim = MODULI[4*i +: 4] - 4'd1;
                    if (ripple)
                        digits_d[4*i +: 4] = up_down ? (fld == lim ? 4'd0 : fld + 4'd1)
                                                     : (fld == 4'd0 ? lim : fld - 4'd1);
                    ripple &= up_down ? fld == lim : fld == 4'd0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            digits_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            digits_q <= digits_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            lerr_q   <= lerr_d;
        end
    end

    assign digits     = digits_q;
    assign carry_out  = carry_q;
    assign overflow   = ovf_q;
    assign load_error = lerr_q;
endmodule
